// File: rtl/byte_packer.sv
// Packs an unthrottled byte stream into 32-bit little-endian words and queues
// them in a small FIFO toward a ready/valid consumer; lost words set a sticky flag.
module byte_packer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 data_in,
  input  logic                       valid_in,
  input  logic                       flush,
  output logic [31:0]                word_out,
  output logic [2:0]                 word_bytes,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int EW = 35;

  // Accumulator state
  logic [31:0]   r_acc;
  logic [1:0]    r_idx;

  // FIFO state
  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;

  // Combinational helpers
  logic [31:0]   w_lane;
  logic [31:0]   w_acc_placed;
  logic          w_push;
  logic [2:0]    w_push_count;
  logic [31:0]   w_push_data;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_drop;
  logic [EW-1:0] w_head;

  assign w_lane       = 32'(data_in) << {r_idx, 3'b000};
  assign w_acc_placed = valid_in ? (r_acc | w_lane) : r_acc;

  // A word closes on the 4th byte, or on flush when at least one byte is present
  // (counting a byte arriving in the same cycle as the flush).
  assign w_push       = (valid_in && (r_idx == 2'd3)) || (flush && (valid_in || (r_idx != 2'd0)));
  assign w_push_count = valid_in ? ({1'b0, r_idx} + 3'd1) : {1'b0, r_idx};
  assign w_push_data  = w_acc_placed;

  assign w_full   = (r_level == LW'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_pop    = !w_empty && word_ready;
  assign w_wr_en  = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (w_push) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (valid_in) begin
      r_acc <= w_acc_placed;
      r_idx <= r_idx + 2'd1;
    end
  end

  // Storage is intentionally left out of reset; only pointers/level define contents.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {w_push_count, w_push_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign word_valid = !w_empty;
  assign word_out   = w_empty ? 32'd0 : w_head[31:0];
  assign word_bytes = w_empty ? 3'd0  : w_head[34:32];
  assign level      = r_level;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_byte_packer.sv
// Directed scoreboard bench for byte_packer: expected words are queued as bytes
// are driven and compared whenever the packer hands a word downstream.
module tb_byte_packer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        flush;
  logic [31:0] word_out;
  logic [2:0]  word_bytes;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  level;
  logic        overflow;

  logic [34:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  byte_packer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .flush      (flush),
    .word_out   (word_out),
    .word_bytes (word_bytes),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .level      (level),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Consumer side: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {29'd0, word_bytes, word_out}, 64'hDEAD);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        check("word_out", {32'd0, word_out}, {32'd0, e[31:0]});
        check("word_bytes", {61'd0, word_bytes}, {61'd0, e[34:32]});
        $display("word 0x%08h bytes %0d (expected 0x%08h bytes %0d)",
                 word_out, word_bytes, e[31:0], e[34:32]);
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic f);
    valid_in = v;
    data_in  = d;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle();
    idle();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    valid_in   = 1'b0;
    data_in    = 8'h00;
    flush      = 1'b0;
    word_ready = 1'b0;
    #1;
    check("rst_valid", 64'(word_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out", {32'd0, word_out}, 64'd0);
    check("rst_bytes", 64'(word_bytes), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);

    // One full word through an always-ready consumer
    word_ready = 1'b1;
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    check("no_early_word", 64'(word_valid), 64'd0);
    exp_q.push_back({3'd4, 32'h44332211});
    cyc(1'b1, 8'h44, 1'b0);
    check("t1_valid", 64'(word_valid), 64'd1);
    check("t1_level", 64'(level), 64'd1);
    idle();
    check("t1_valid_1cyc", 64'(word_valid), 64'd0);
    check("t1_level0", 64'(level), 64'd0);

    // Partial word via flush, then a flush with nothing buffered
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0);
    exp_q.push_back({3'd2, 32'h0000BBAA});
    cyc(1'b0, 8'h00, 1'b1);
    check("t2_valid", 64'(word_valid), 64'd1);
    idle();
    cyc(1'b0, 8'h00, 1'b1);
    check("t2_empty_flush", 64'(word_valid), 64'd0);
    check("t2_level", 64'(level), 64'd0);

    // Flush coinciding with the 4th byte yields a single full word
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    exp_q.push_back({3'd4, 32'h04030201});
    cyc(1'b1, 8'h04, 1'b1);
    check("t3_level", 64'(level), 64'd1);
    idle();
    idle();
    check("t3_level0", 64'(level), 64'd0);
    check("t3_q", 64'(exp_q.size()), 64'd0);

    // Stalled consumer: fifth word is dropped
    word_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((i % 4) == 3 && i < 16) begin
        exp_q.push_back({3'd4, 8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
      end
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 11) check("t4_level3", 64'(level), 64'd3);
      if (i == 15) begin
        check("t4_level4", 64'(level), 64'd4);
        check("t4_no_ovf_yet", 64'(overflow), 64'd0);
      end
    end
    check("t4_ovf", 64'(overflow), 64'd1);
    check("t4_level_full", 64'(level), 64'd4);
    check("t4_head_stable", {32'd0, word_out}, 64'h03020100);
    idle();
    check("t4_head_stable2", {32'd0, word_out}, 64'h03020100);
    word_ready = 1'b1;
    drain("t4_drain");
    check("t4_ovf_sticky", 64'(overflow), 64'd1);
    check("t4_level_end", 64'(level), 64'd0);

    // Full FIFO with a pop on the same edge as a completing push
    do_reset();
    check("t5_ovf_cleared", 64'(overflow), 64'd0);
    word_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if ((i % 4) == 3) begin
        exp_q.push_back({3'd4, 8'(8'h20 + i), 8'(8'h1F + i), 8'(8'h1E + i), 8'(8'h1D + i)});
      end
      cyc(1'b1, 8'(8'h20 + i), 1'b0);
    end
    check("t5_full", 64'(level), 64'd4);
    cyc(1'b1, 8'h30, 1'b0);
    cyc(1'b1, 8'h31, 1'b0);
    cyc(1'b1, 8'h32, 1'b0);
    word_ready = 1'b1;
    exp_q.push_back({3'd4, 32'h33323130});
    cyc(1'b1, 8'h33, 1'b0);
    check("t5_level_stays", 64'(level), 64'd4);
    check("t5_no_ovf", 64'(overflow), 64'd0);
    drain("t5_drain");
    check("t5_level_end", 64'(level), 64'd0);

    // Asynchronous reset in the middle of a burst
    word_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if ((i % 4) == 3) begin
        exp_q.push_back({3'd4, 8'(8'h40 + i), 8'(8'h3F + i), 8'(8'h3E + i), 8'(8'h3D + i)});
      end
      cyc(1'b1, 8'(8'h40 + i), 1'b0);
    end
    check("t6_level3", 64'(level), 64'd3);
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    exp_q.delete();
    check("t6_valid", 64'(word_valid), 64'd0);
    check("t6_out", {32'd0, word_out}, 64'd0);
    check("t6_bytes", 64'(word_bytes), 64'd0);
    check("t6_level", 64'(level), 64'd0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    word_ready = 1'b1;
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h66, 1'b0);
    cyc(1'b1, 8'h77, 1'b0);
    exp_q.push_back({3'd4, 32'h88776655});
    cyc(1'b1, 8'h88, 1'b0);
    check("t6_word", {32'd0, word_out}, 64'h88776655);
    drain("t6_drain");
    check("t6_ovf", 64'(overflow), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
